hpi_responder: RTL and testbench

HPI_RESPONDER -- requirements
Module: hpi_responder

---
 rtl/hpi_pkg.sv | 10 +
 rtl/hpi_ram.sv | 23 ++
 rtl/hpi_responder.sv | 95 +++++++++
 tb/tb_hpi_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// hpi_pkg: register-select encoding and default memory geometry for the HPI responder.
package hpi_pkg;
  localparam int MEM_AW_DEF = 8;
  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;
endpackage

// File: rtl/hpi_ram.sv
// hpi_ram: 16-bit word memory, two write ports (port a wins on a shared word), one registered read port.
module hpi_ram #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [15:0]   i_wdata_a,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_addr_b,
  input  logic [15:0]   i_wdata_b,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);
  logic [15:0] r_mem [2**AW];
  // Port a is written last so its value lands when both target the same word.
  always_ff @(posedge i_clk) begin
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/hpi_responder.sv
// hpi_responder: host-port-interface slave with auto-incrementing word memory window and two mailboxes.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [1:0]        OTG_ADDR,
  input  logic [15:0]       OTG_DATA_IN,
  output logic [15:0]       OTG_DATA_OUT,
  output logic              OTG_DATA_OE,
  input  logic              OTG_CS_N,
  input  logic              OTG_RD_N,
  input  logic              OTG_WR_N,
  input  logic              OTG_RST_N,
  output logic              OTG_INT,
  input  logic              loc_we,
  input  logic [MEM_AW-1:0] loc_addr,
  input  logic [15:0]       loc_wdata,
  input  logic              loc_mbx_wr,
  input  logic [15:0]       loc_mbx_data,
  output logic [15:0]       h2d_data,
  output logic              h2d_valid,
  input  logic              h2d_ack
);
  logic        r_rd, r_wr, r_oe, r_dsel, r_d2h_pend;
  logic [15:0] r_addr, r_rdata, r_d2h;
  logic        w_rst, w_rd_s, w_wr_s, w_rd_edge, w_wr_edge, w_data_rd, w_data_wr;
  logic [15:0] w_rd_mux, w_ram_q;
  hpi_reg_e    w_sel;
  assign w_sel     = hpi_reg_e'(OTG_ADDR);
  assign w_rst     = ~Reset_n | ~OTG_RST_N;
  assign w_rd_s    = ~OTG_CS_N & ~OTG_RD_N;
  assign w_wr_s    = ~OTG_CS_N & ~OTG_WR_N;
  // Simultaneous read and write strobes are treated as a bus conflict: no access.
  assign w_rd_edge = w_rd_s & ~r_rd & ~w_wr_s & ~w_rst;
  assign w_wr_edge = w_wr_s & ~r_wr & ~w_rd_s & ~w_rst;
  assign w_data_rd = w_rd_edge & (w_sel == HPI_DATA);
  assign w_data_wr = w_wr_edge & (w_sel == HPI_DATA);
  always_comb begin
    w_rd_mux = (w_sel == HPI_ADDRESS) ? r_addr :
               (w_sel == HPI_MAILBOX) ? r_d2h :
               (w_sel == HPI_STATUS)  ? {14'b0, h2d_valid, r_d2h_pend} : 16'h0000;
  end
  hpi_ram #(.AW(MEM_AW)) u_ram (
    .i_clk    (Clk),
    .i_we_a   (w_data_wr),
    .i_addr_a (r_addr[MEM_AW:1]),
    .i_wdata_a(OTG_DATA_IN),
    .i_we_b   (loc_we),
    .i_addr_b (loc_addr),
    .i_wdata_b(loc_wdata),
    .i_re     (w_data_rd),
    .i_raddr  (r_addr[MEM_AW:1]),
    .o_rdata  (w_ram_q)
  );
  // Memory reads land in the RAM output register; r_dsel steers the bus to it.
  assign OTG_DATA_OUT = r_dsel ? w_ram_q : r_rdata;
  assign OTG_DATA_OE  = r_oe;
  assign OTG_INT      = r_d2h_pend;
  always_ff @(posedge Clk) begin
    if (w_rst) begin
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_oe       <= 1'b0;
      r_dsel     <= 1'b0;
      r_rdata    <= 16'h0000;
      r_addr     <= 16'h0000;
      r_d2h      <= 16'h0000;
      r_d2h_pend <= 1'b0;
      h2d_data   <= 16'h0000;
      h2d_valid  <= 1'b0;
    end else begin
      r_rd <= w_rd_s;
      r_wr <= w_wr_s;
      r_oe <= w_rd_s & ~w_wr_s;
      if (w_data_rd | w_data_wr) r_addr <= r_addr + 16'd2;
      else if (w_wr_edge && w_sel == HPI_ADDRESS) r_addr <= OTG_DATA_IN;
      if (w_rd_edge) begin
        r_dsel  <= (w_sel == HPI_DATA);
        r_rdata <= w_rd_mux;
      end
      if (w_wr_edge && w_sel == HPI_MAILBOX) begin
        h2d_data  <= OTG_DATA_IN;
        h2d_valid <= 1'b1;
      end else if (h2d_ack) h2d_valid <= 1'b0;
      // A local post in the same cycle as a host mailbox read keeps the interrupt up.
      if (loc_mbx_wr) begin
        r_d2h      <= loc_mbx_data;
        r_d2h_pend <= 1'b1;
      end else if (w_rd_edge && w_sel == HPI_MAILBOX) r_d2h_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: directed self-checking bench for hpi_responder.
module tb_hpi_responder;
  import hpi_pkg::*;
  logic        Clk = 1'b0;
  logic        Reset_n, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N, OTG_DATA_OE, OTG_INT;
  logic [1:0]  OTG_ADDR;
  logic [15:0] OTG_DATA_IN, OTG_DATA_OUT, loc_wdata, loc_mbx_data, h2d_data;
  logic [7:0]  loc_addr;
  logic        loc_we, loc_mbx_wr, h2d_valid, h2d_ack;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] rd;
  always #5 Clk = ~Clk;
  hpi_responder #(.MEM_AW(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .OTG_ADDR(OTG_ADDR), .OTG_DATA_IN(OTG_DATA_IN),
    .OTG_DATA_OUT(OTG_DATA_OUT), .OTG_DATA_OE(OTG_DATA_OE), .OTG_CS_N(OTG_CS_N),
    .OTG_RD_N(OTG_RD_N), .OTG_WR_N(OTG_WR_N), .OTG_RST_N(OTG_RST_N), .OTG_INT(OTG_INT),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_mbx_wr(loc_mbx_wr),
    .loc_mbx_data(loc_mbx_data), .h2d_data(h2d_data), .h2d_valid(h2d_valid), .h2d_ack(h2d_ack)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic hwr(input logic [1:0] a, input logic [15:0] d);
    @(negedge Clk);
    OTG_ADDR = a; OTG_DATA_IN = d; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1;
  endtask
  task automatic rchk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    @(negedge Clk);
    OTG_ADDR = a; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    @(negedge Clk);
    chk(tag, OTG_DATA_OUT, exp);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
  endtask
  task automatic post(input logic [15:0] d);
    @(negedge Clk);
    loc_mbx_wr = 1'b1; loc_mbx_data = d;
    @(negedge Clk);
    loc_mbx_wr = 1'b0;
  endtask
  initial begin
    Reset_n = 1'b0; OTG_RST_N = 1'b1; OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
    OTG_ADDR = 2'd0; OTG_DATA_IN = 16'h0; loc_we = 1'b0; loc_addr = 8'h0; loc_wdata = 16'h0;
    loc_mbx_wr = 1'b0; loc_mbx_data = 16'h0; h2d_ack = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_out", OTG_DATA_OUT, 16'h0000);
    chk("rst_oe", {15'b0, OTG_DATA_OE}, 16'h0);
    chk("rst_int", {15'b0, OTG_INT}, 16'h0);
    chk("rst_h2d", h2d_data, 16'h0000);
    chk("rst_h2dv", {15'b0, h2d_valid}, 16'h0);
    Reset_n = 1'b1;
    rchk("rst_status", HPI_STATUS, 16'h0000);
    rchk("rst_addr", HPI_ADDRESS, 16'h0000);
    hwr(HPI_ADDRESS, 16'h0010);
    hwr(HPI_DATA, 16'h1111);
    hwr(HPI_DATA, 16'h2222);
    rchk("autoinc_wr", HPI_ADDRESS, 16'h0014);
    hwr(HPI_ADDRESS, 16'h0010);
    rchk("rd_1111", HPI_DATA, 16'h1111);
    rchk("rd_2222", HPI_DATA, 16'h2222);
    rchk("autoinc_rd", HPI_ADDRESS, 16'h0014);
    hwr(HPI_ADDRESS, 16'hFFFE);
    hwr(HPI_DATA, 16'hABCD);
    rchk("addr_wrap", HPI_ADDRESS, 16'h0000);
    hwr(HPI_ADDRESS, 16'h01FE);
    rchk("alias_ff", HPI_DATA, 16'hABCD);
    post(16'h00A5);
    chk("int_set", {15'b0, OTG_INT}, 16'h1);
    rchk("status_d2h", HPI_STATUS, 16'h0001);
    rchk("mbx_rd_a5", HPI_MAILBOX, 16'h00A5);
    chk("int_clr", {15'b0, OTG_INT}, 16'h0);
    post(16'h0011);
    @(negedge Clk);
    OTG_ADDR = HPI_MAILBOX; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; loc_mbx_wr = 1'b1; loc_mbx_data = 16'h005A;
    @(negedge Clk);
    chk("mbx_rd_old", OTG_DATA_OUT, 16'h0011);
    chk("int_keep", {15'b0, OTG_INT}, 16'h1);
    loc_mbx_wr = 1'b0; OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    rchk("mbx_rd_5a", HPI_MAILBOX, 16'h005A);
    chk("int_clr2", {15'b0, OTG_INT}, 16'h0);
    hwr(HPI_MAILBOX, 16'h1234);
    chk("h2d_data", h2d_data, 16'h1234);
    chk("h2d_valid", {15'b0, h2d_valid}, 16'h1);
    rchk("status_h2d", HPI_STATUS, 16'h0002);
    @(negedge Clk); h2d_ack = 1'b1;
    @(negedge Clk); h2d_ack = 1'b0;
    chk("h2d_ack", {15'b0, h2d_valid}, 16'h0);
    @(negedge Clk);
    OTG_ADDR = HPI_MAILBOX; OTG_DATA_IN = 16'h4321; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0; h2d_ack = 1'b1;
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; h2d_ack = 1'b0;
    chk("wr_ack_valid", {15'b0, h2d_valid}, 16'h1);
    chk("wr_ack_data", h2d_data, 16'h4321);
    @(negedge Clk); h2d_ack = 1'b1;
    @(negedge Clk); h2d_ack = 1'b0;
    chk("h2d_ack2", {15'b0, h2d_valid}, 16'h0);
    hwr(HPI_ADDRESS, 16'h000A);
    @(negedge Clk);
    OTG_ADDR = HPI_DATA; OTG_DATA_IN = 16'h8888; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    loc_we = 1'b1; loc_addr = 8'h05; loc_wdata = 16'h7777;
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; loc_we = 1'b0;
    hwr(HPI_ADDRESS, 16'h000E);
    @(negedge Clk);
    OTG_ADDR = HPI_DATA; OTG_DATA_IN = 16'h9999; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    loc_we = 1'b1; loc_addr = 8'h06; loc_wdata = 16'h6666;
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; loc_we = 1'b0;
    hwr(HPI_ADDRESS, 16'h000A);
    rchk("host_wins", HPI_DATA, 16'h8888);
    rchk("loc_word6", HPI_DATA, 16'h6666);
    rchk("host_word7", HPI_DATA, 16'h9999);
    hwr(HPI_ADDRESS, 16'h0020);
    @(negedge Clk);
    OTG_ADDR = HPI_DATA; OTG_DATA_IN = 16'hDEAD; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_WR_N = 1'b0;
    @(negedge Clk);
    chk("conflict_oe", {15'b0, OTG_DATA_OE}, 16'h0);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
    rchk("conflict_addr", HPI_ADDRESS, 16'h0020);
    hwr(HPI_ADDRESS, 16'h0000);
    hwr(HPI_DATA, 16'h5555);
    hwr(HPI_ADDRESS, 16'h0010);
    @(negedge Clk);
    OTG_ADDR = HPI_DATA; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    @(negedge Clk);
    chk("pre_rst_out", OTG_DATA_OUT, 16'h1111);
    chk("pre_rst_oe", {15'b0, OTG_DATA_OE}, 16'h1);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("midrst_out", OTG_DATA_OUT, 16'h0000);
    chk("midrst_oe", {15'b0, OTG_DATA_OE}, 16'h0);
    chk("midrst_int", {15'b0, OTG_INT}, 16'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_out", OTG_DATA_OUT, 16'h5555);
    chk("post_rst_oe", {15'b0, OTG_DATA_OE}, 16'h1);
    repeat (3) @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    rchk("single_access", HPI_ADDRESS, 16'h0002);
    hwr(HPI_ADDRESS, 16'h0010);
    rchk("mem_kept", HPI_DATA, 16'h1111);
    post(16'h0077);
    chk("soft_pre_int", {15'b0, OTG_INT}, 16'h1);
    @(negedge Clk); OTG_RST_N = 1'b0;
    @(negedge Clk); OTG_RST_N = 1'b1;
    chk("soft_int", {15'b0, OTG_INT}, 16'h0);
    rchk("soft_addr", HPI_ADDRESS, 16'h0000);
    rd = 16'h0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
